hamming_block_dec_ctrl: RTL and testbench
=========================================

Name: hamming_block_dec_ctrl

Overview:
Sequencer that walks a block of Hamming(15,11) codewords stored in byte-wide data memory and writes the corrected 11-bit data words back to a destination region. Per codeword it reads two bytes, runs them through a combinational single-error-correcting decoder, and writes two bytes back. It counts corrected codewords, owns the data-memory port while busy, and signals completion to the core.

Parameters:
ADDR_W, 8, data-memory byte address width
SRC_BASE, 30, byte address of first codeword low byte
DST_BASE, 0, byte address of first decoded low byte
NUM_WORDS, 15, codewords per run (1..2^ADDR_W/2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a run; sampled only in IDLE
mem_addr  out  ADDR_W  data-memory byte address
mem_we  out  1  write enable
mem_wdata  out  8  write data
mem_rdata  in  8  read data; valid one cycle after address is presented
busy  out  1  high from cycle after accepted start until DONE completes
done  out  1  one-cycle pulse at end of run
err_cnt  out  $clog2(NUM_WORDS+1)  codewords with non-zero syndrome in current/last run

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n). On assertion: state=IDLE, busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0, err_cnt=0, word index=0.
- Codeword k layout: lo byte at SRC_BASE+2k, hi byte at SRC_BASE+2k+1. d_in[15:1] = {hi[6:0], lo[7:0]}; hi[7] ignored. Parity bits are at positions 8,4,2,1. Data positions are 15..9, 7..5, 3, in that order, forming d[11:1].
- Syndrome: s8 = xor of positions with bit3 set, s4 = bit2 set, s2 = bit1 set, s1 = bit0 set, over all 15 positions. A non-zero syndrome flips that position before data extraction, including parity positions, where data is unchanged. Double errors are not detected; miscorrection is accepted.
- Output for word k: DST_BASE+2k gets d[8:1]; DST_BASE+2k+1 gets {5'b0, d[11:9]}.
- FSM states and transitions:
  - IDLE: start=1 goes to RD_LO and clears err_cnt and index.
  - RD_LO: mem_addr=src lo. Goes to RD_HI.
  - RD_HI: mem_addr=src hi; capture lo_q<=mem_rdata. Goes to CAP_HI.
  - CAP_HI: capture hi_q<=mem_rdata. Goes to WR_LO.
  - WR_LO: mem_we=1, addr=dst lo, wdata from decode of {hi_q,lo_q}. If syndrome!=0, err_cnt+=1. Goes to WR_HI.
  - WR_HI: mem_we=1, addr=dst hi. If index==NUM_WORDS-1, go to DONE; else index+=1 and go to RD_LO.
  - DONE: done=1 for exactly one cycle, busy=0 next cycle. Goes to IDLE.
- Latency: 5 cycles per codeword. First RD_LO is the cycle after start is sampled; done asserts at cycle 5*NUM_WORDS+1 after the start edge.
- mem_we is high only in WR_LO/WR_HI. Addresses are combinational from state and index, and all writes are registered into the memory.
- err_cnt holds its value after DONE until the next accepted start. It never wraps because its width covers NUM_WORDS.
- start while not IDLE is ignored, with no restart. start held high through DONE begins a new run from IDLE on the following cycle.
- Address arithmetic is modulo 2^ADDR_W. Overlapping src/dst regions are the caller's responsibility.
- Reset mid-run aborts immediately: mem_we drops asynchronously and partial writes remain in memory.

Decomposition:
- Shared package holds:
  - state enum (IDLE, RD_LO, RD_HI, CAP_HI, WR_LO, WR_HI, DONE)
  - parity position constants (8,4,2,1)
  - codeword/data width localparams (15, 11)
- One sub-module, hamming15_11_dec: combinational; d_in[15:1] in; d_out[11:1] and syndrome[3:0] out. The controller instantiates it on {hi_q[6:0], lo_q}.

Test Plan:
- Clean run: all 15 codewords lo=8'hFF, hi=8'h7F -> every dst pair = 8'hFF, 8'h07; err_cnt=0; done pulses exactly 76 cycles after start edge; busy low afterwards.
- Data-bit error: word 0 lo=8'hFB (position 3 flipped), rest clean -> dst[0]=8'hFF, dst[1]=8'h07; err_cnt=1.
- Parity-bit error: word 14 lo=8'h7F (position 8 flipped), and word 5 all-zero codeword with position 15 flipped (hi=8'h40) -> word 14 output FF/07, word 5 output 00/00; err_cnt=2.
- start pulsed again at cycles 10 and 40 of a run -> ignored; single done at cycle 76; 30 writes total.
- rst_n low at cycle 23 -> mem_we=0 same cycle, busy=0, err_cnt=0. A new start after release completes a full run with correct results.
- Back-to-back: start held high continuously -> second run's RD_LO follows IDLE one cycle after DONE; err_cnt cleared at second start; results identical.

Source files
------------

// File: rtl/hamming_block_dec_ctrl_pkg.sv
// hamming_block_dec_ctrl_pkg: shared types and Hamming(15,11) layout constants
package hamming_block_dec_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, CAP_HI, WR_LO, WR_HI, DONE} state_t;
  localparam int CW_W = 15;
  localparam int DATA_W = 11;
  localparam int PAR_POS [4] = '{8, 4, 2, 1};
  localparam int DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
endpackage

// File: rtl/hamming15_11_dec.sv
// hamming15_11_dec: combinational single-error-correcting Hamming(15,11) decoder
module hamming15_11_dec
  import hamming_block_dec_ctrl_pkg::*;
(
  input  logic [CW_W:1]   d_in,
  output logic [DATA_W:1] d_out,
  output logic [3:0]      syndrome
);
  always_comb begin
    syndrome = '0;
    for (int j = 0; j < 4; j++)
      for (int p = 1; p <= CW_W; p++)
        if ((p & PAR_POS[j]) != 0) syndrome[3-j] = syndrome[3-j] ^ d_in[p];
    // a syndrome pointing at a parity position leaves every data bit untouched
    for (int i = 0; i < DATA_W; i++)
      d_out[i+1] = d_in[DATA_POS[i]] ^ (syndrome == 4'(DATA_POS[i]));
  end
endmodule

// File: rtl/hamming_block_dec_ctrl.sv
// hamming_block_dec_ctrl: walks a block of Hamming(15,11) codewords in memory and writes back corrected data
module hamming_block_dec_ctrl
  import hamming_block_dec_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0,
  parameter int NUM_WORDS = 15
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  output logic [ADDR_W-1:0]                  mem_addr,
  output logic                               mem_we,
  output logic [7:0]                         mem_wdata,
  input  logic [7:0]                         mem_rdata,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(NUM_WORDS+1)-1:0]     err_cnt
);
  localparam int CNT_W = $clog2(NUM_WORDS + 1);
  localparam int IDX_W = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
  state_t state, nxt;
  logic [IDX_W-1:0] idx;
  logic [7:0] lo_q, hi_q;
  logic [DATA_W:1] d;
  logic [3:0] syn;
  logic [ADDR_W-1:0] off;
  logic rd, wr, hi_sel, last;
  logic unused_hi;
  assign unused_hi = hi_q[7];
  hamming15_11_dec u_dec (
    .d_in    ({hi_q[6:0], lo_q}),
    .d_out   (d),
    .syndrome(syn)
  );
  always_comb begin
    rd = state == RD_LO || state == RD_HI;
    wr = state == WR_LO || state == WR_HI;
    hi_sel = state == RD_HI || state == WR_HI;
    last = idx == IDX_W'(NUM_WORDS - 1);
    off = ADDR_W'({idx, 1'b0}) + ADDR_W'(hi_sel);
    mem_addr = rd ? ADDR_W'(SRC_BASE) + off : wr ? ADDR_W'(DST_BASE) + off : '0;
    mem_we = wr;
    mem_wdata = state == WR_LO ? d[8:1] : state == WR_HI ? {5'b0, d[11:9]} : '0;
    busy = state != IDLE;
    done = state == DONE;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? RD_LO : IDLE;
      RD_LO:   nxt = RD_HI;
      RD_HI:   nxt = CAP_HI;
      CAP_HI:  nxt = WR_LO;
      WR_LO:   nxt = WR_HI;
      WR_HI:   nxt = last ? DONE : RD_LO;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      err_cnt <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        idx     <= '0;
        err_cnt <= '0;
      end
      if (state == RD_HI) lo_q <= mem_rdata;
      if (state == CAP_HI) hi_q <= mem_rdata;
      if (state == WR_LO && syn != 4'd0) err_cnt <= err_cnt + CNT_W'(1);
      if (state == WR_HI && !last) idx <= idx + IDX_W'(1);
    end
  end
endmodule

// File: tb/tb_hamming_block_dec_ctrl.sv
// tb_hamming_block_dec_ctrl: randomized self-checking bench with a nearest-codeword reference model
module tb_hamming_block_dec_ctrl;
  localparam int SRC = 30;
  localparam int DST = 0;
  localparam int NW  = 15;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic mem_we, busy, done;
  logic [3:0] err_cnt;
  logic [7:0] mem [256];
  logic [7:0] exp_mem [2*NW];
  int exp_err;
  int n_tests = 0;
  int n_fail = 0;
  int data_pos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
  always #5 clk = ~clk;
  hamming_block_dec_ctrl #(.ADDR_W(8), .SRC_BASE(SRC), .DST_BASE(DST), .NUM_WORDS(NW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .done     (done),
    .err_cnt  (err_cnt)
  );
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // bit p of the result is codeword position p; bit 0 unused
  function automatic logic [15:0] enc(input int v);
    logic [15:0] c;
    c = '0;
    for (int i = 0; i < 11; i++) c[data_pos[i]] = v[i];
    for (int j = 0; j < 4; j++)
      for (int q = 1; q <= 15; q++)
        if ((q & (1 << j)) != 0 && q != (1 << j)) c[1 << j] = c[1 << j] ^ c[q];
    return c;
  endfunction
  // the code is perfect: every 15-bit word lies within distance 1 of exactly one codeword
  task automatic ref_word(input logic [7:0] lo, input logic [7:0] hi,
                          output logic [7:0] olo, output logic [7:0] ohi, output int err);
    logic [15:0] x;
    int n;
    x = {hi[6:0], lo, 1'b0};
    olo = '0;
    ohi = '0;
    err = 0;
    for (int v = 0; v < 2048; v++) begin
      n = $countones(enc(v) ^ x);
      if (n <= 1) begin
        olo = v[7:0];
        ohi = {5'b0, v[10:8]};
        err = n;
        break;
      end
    end
  endtask
  task automatic build_model();
    int e;
    exp_err = 0;
    for (int k = 0; k < NW; k++) begin
      ref_word(mem[SRC+2*k], mem[SRC+2*k+1], exp_mem[2*k], exp_mem[2*k+1], e);
      exp_err += e;
    end
  endtask
  task automatic clear_dst();
    for (int i = 0; i < 2*NW; i++) mem[DST+i] = 8'hAA;
  endtask
  task automatic fill_clean();
    for (int k = 0; k < NW; k++) begin
      mem[SRC+2*k] = 8'hFF;
      mem[SRC+2*k+1] = 8'h7F;
    end
  endtask
  task automatic fill_random();
    logic [15:0] c;
    for (int k = 0; k < NW; k++) begin
      c = enc(int'($urandom_range(0, 2047)));
      repeat ($urandom_range(0, 2)) c[$urandom_range(1, 15)] ^= 1'b1;
      mem[SRC+2*k] = c[8:1];
      mem[SRC+2*k+1] = {1'($urandom_range(0, 1)), c[15:9]};
    end
  endtask
  task automatic run(input bit extra, input bit keep, input bit pre, input string tag);
    int cyc, dcyc, wr;
    build_model();
    if (!pre) begin
      @(negedge clk);
      start = 1'b1;
    end
    cyc = 0;
    dcyc = 0;
    wr = 0;
    while (dcyc == 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = keep || (extra && (cyc == 10 || cyc == 40));
      if (cyc == 1) begin
        check({tag, "/busy_first"}, busy, 1);
        check({tag, "/err_cleared"}, err_cnt, 0);
      end
      if (mem_we) wr++;
      if (done) dcyc = cyc;
    end
    check({tag, "/done_cycle"}, dcyc, 5*NW+1);
    check({tag, "/writes"}, wr, 2*NW);
    @(negedge clk);
    check({tag, "/done_pulse"}, done, 0);
    check({tag, "/busy_after"}, busy, 0);
    check({tag, "/err_cnt"}, err_cnt, exp_err);
    for (int i = 0; i < 2*NW; i++) check({tag, "/dst"}, mem[DST+i], exp_mem[i]);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst/busy", busy, 0);
    check("rst/done", done, 0);
    check("rst/we", mem_we, 0);
    check("rst/addr", mem_addr, 0);
    check("rst/wdata", mem_wdata, 0);
    check("rst/err", err_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    fill_clean(); clear_dst();
    run(0, 0, 0, "clean");
    check("clean/lo0", mem[DST], 8'hFF);
    check("clean/hi0", mem[DST+1], 8'h07);
    fill_clean(); clear_dst();
    mem[SRC] = 8'hFB;
    run(0, 0, 0, "data_err");
    check("data_err/lo0", mem[DST], 8'hFF);
    check("data_err/hi0", mem[DST+1], 8'h07);
    check("data_err/cnt", err_cnt, 1);
    fill_clean(); clear_dst();
    mem[SRC+28] = 8'h7F;
    mem[SRC+10] = 8'h00;
    mem[SRC+11] = 8'h40;
    run(0, 0, 0, "par_err");
    check("par_err/lo14", mem[DST+28], 8'hFF);
    check("par_err/hi14", mem[DST+29], 8'h07);
    check("par_err/lo5", mem[DST+10], 8'h00);
    check("par_err/hi5", mem[DST+11], 8'h00);
    check("par_err/cnt", err_cnt, 2);
    fill_random(); clear_dst();
    run(1, 0, 0, "extra_start");
    for (int r = 0; r < 4; r++) begin
      fill_random(); clear_dst();
      run(0, 0, 0, $sformatf("rand%0d", r));
    end
    fill_random(); clear_dst(); build_model();
    @(negedge clk);
    start = 1'b1;
    repeat (24) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("abort/we_before", mem_we, 1);
    rst_n = 1'b0;
    #1;
    check("abort/we", mem_we, 0);
    check("abort/busy", busy, 0);
    check("abort/err", err_cnt, 0);
    check("abort/addr", mem_addr, 0);
    for (int i = 0; i < 8; i++) check("abort/partial", mem[DST+i], exp_mem[i]);
    check("abort/unwritten", mem[DST+8], 8'hAA);
    @(negedge clk);
    rst_n = 1'b1;
    clear_dst();
    run(0, 0, 0, "after_rst");
    fill_clean(); clear_dst();
    mem[SRC+4] = mem[SRC+4] ^ 8'h10;
    run(0, 1, 0, "b2b_first");
    clear_dst();
    run(0, 0, 1, "b2b_second");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
